// File: rtl/alu_decode_pkg.sv
// Shared field layout for the ALU decode stage and its scoreboard.
package alu_decode_pkg;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned PERCI_W  = 2;
    localparam int unsigned WRITE_W  = 2;

    // Instruction fields, listed from LSB to MSB of the packed word.
    typedef enum logic [3:0] {
        FldA, FldB, FldC, FldD, FldY1, FldY2, FldWrite, FldPerci, FldForm, FldOp, FldConstA
    } field_e;

    function automatic int unsigned instr_w(input int unsigned sel_w);
        return 1 + ALU_OP_W + 1 + PERCI_W + WRITE_W + 6 * sel_w;
    endfunction

    function automatic int unsigned field_lsb(input field_e f, input int unsigned sel_w);
        case (f)
            FldA:      return 0;
            FldB:      return sel_w;
            FldC:      return 2 * sel_w;
            FldD:      return 3 * sel_w;
            FldY1:     return 4 * sel_w;
            FldY2:     return 5 * sel_w;
            FldWrite:  return 6 * sel_w;
            FldPerci:  return 6 * sel_w + WRITE_W;
            FldForm:   return 6 * sel_w + WRITE_W + PERCI_W;
            FldOp:     return 6 * sel_w + WRITE_W + PERCI_W + 1;
            FldConstA: return 6 * sel_w + WRITE_W + PERCI_W + 1 + ALU_OP_W;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, cleared by writeback and
// set by issued writes, with a combinational hazard check for the held instruction.
module alu_scoreboard #(
    parameter int unsigned SEL_W = 4,
    localparam int unsigned NREG = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [SEL_W-1:0] wb_sel,
    input  logic             set_y1,
    input  logic             set_y2,
    input  logic [SEL_W-1:0] a_sel,
    input  logic [SEL_W-1:0] b_sel,
    input  logic [SEL_W-1:0] c_sel,
    input  logic [SEL_W-1:0] d_sel,
    input  logic [SEL_W-1:0] y1_sel,
    input  logic [SEL_W-1:0] y2_sel,
    input  logic             chk_a,
    input  logic             chk_y1,
    input  logic             chk_y2,
    output logic             hazard,
    output logic [NREG-1:0]  busy_mask
);

    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] fire_set;
    logic [NREG-1:0] eff;
    logic [NREG-1:0] busy_d;

    // Writeback clears first so a same-cycle writeback unblocks; fire sets win.
    always_comb begin
        wb_clr   = '0;
        fire_set = '0;
        if (wb_valid) wb_clr[wb_sel] = 1'b1;
        if (set_y1)   fire_set[y1_sel] = 1'b1;
        if (set_y2)   fire_set[y2_sel] = 1'b1;
        eff    = busy_mask & ~wb_clr;
        busy_d = eff | fire_set;
        hazard = (chk_a & eff[a_sel]) | eff[b_sel] | eff[c_sel] | eff[d_sel]
               | (chk_y1 & eff[y1_sel]) | (chk_y2 & eff[y2_sel]);
    end

    // Busy register.
    always_ff @(posedge clk) begin
        if (rst) busy_mask <= '0;
        else     busy_mask <= busy_d;
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered, handshaked ALU decode stage: holds one instruction until its
// sources and destinations are clear of in-flight writes, then issues it.
module alu_decode_stage import alu_decode_pkg::*; #(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned INSTR_W = 10 + 6 * SEL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  alu_form,
    output logic [PERCI_W-1:0]    alu_vector_perci,
    output logic                  const_a,
    output logic [SEL_W-1:0]      alu_a_select,
    output logic [SEL_W-1:0]      alu_b_select,
    output logic [SEL_W-1:0]      alu_c_select,
    output logic [SEL_W-1:0]      alu_d_select,
    output logic [SEL_W-1:0]      alu_y1_select,
    output logic [SEL_W-1:0]      alu_y2_select,
    output logic [WRITE_W-1:0]    write,
    input  logic                  wb_valid,
    input  logic [SEL_W-1:0]      wb_sel,
    input  logic                  flush,
    output logic [CNT_W-1:0]      stall_count,
    output logic [(1<<SEL_W)-1:0] busy_mask
);

    localparam int unsigned A_LSB   = field_lsb(FldA, SEL_W);
    localparam int unsigned B_LSB   = field_lsb(FldB, SEL_W);
    localparam int unsigned C_LSB   = field_lsb(FldC, SEL_W);
    localparam int unsigned D_LSB   = field_lsb(FldD, SEL_W);
    localparam int unsigned Y1_LSB  = field_lsb(FldY1, SEL_W);
    localparam int unsigned Y2_LSB  = field_lsb(FldY2, SEL_W);
    localparam int unsigned WR_LSB  = field_lsb(FldWrite, SEL_W);
    localparam int unsigned PC_LSB  = field_lsb(FldPerci, SEL_W);
    localparam int unsigned FM_LSB  = field_lsb(FldForm, SEL_W);
    localparam int unsigned OP_LSB  = field_lsb(FldOp, SEL_W);
    localparam int unsigned CA_LSB  = field_lsb(FldConstA, SEL_W);

    logic held_q;
    logic held_d;
    logic hazard;
    logic fire;
    logic accept;

    // Handshake: flush blocks both issue and accept for the cycle.
    always_comb begin
        out_valid = held_q && !hazard && !flush;
        fire      = out_valid && out_ready;
        in_ready  = (!held_q || fire) && !flush;
        accept    = in_valid && in_ready;
        held_d    = held_q;
        if (flush)       held_d = 1'b0;
        else if (accept) held_d = 1'b1;
        else if (fire)   held_d = 1'b0;
    end

    // Held flag, decoded fields and saturating hazard-stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q           <= 1'b0;
            alu_op           <= '0;
            alu_form         <= 1'b0;
            alu_vector_perci <= '0;
            const_a          <= 1'b0;
            alu_a_select     <= '0;
            alu_b_select     <= '0;
            alu_c_select     <= '0;
            alu_d_select     <= '0;
            alu_y1_select    <= '0;
            alu_y2_select    <= '0;
            write            <= '0;
            stall_count      <= '0;
        end else begin
            held_q <= held_d;
            if (accept) begin
                alu_op           <= in_instr[OP_LSB +: ALU_OP_W];
                alu_form         <= in_instr[FM_LSB];
                alu_vector_perci <= in_instr[PC_LSB +: PERCI_W];
                const_a          <= in_instr[CA_LSB];
                alu_a_select     <= in_instr[A_LSB +: SEL_W];
                alu_b_select     <= in_instr[B_LSB +: SEL_W];
                alu_c_select     <= in_instr[C_LSB +: SEL_W];
                alu_d_select     <= in_instr[D_LSB +: SEL_W];
                alu_y1_select    <= in_instr[Y1_LSB +: SEL_W];
                alu_y2_select    <= in_instr[Y2_LSB +: SEL_W];
                write            <= in_instr[WR_LSB +: WRITE_W];
            end
            if (held_q && hazard && !flush && stall_count != {CNT_W{1'b1}}) begin
                stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    alu_scoreboard #(
        .SEL_W (SEL_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_sel    (wb_sel),
        .set_y1    (fire && write[0]),
        .set_y2    (fire && write[1]),
        .a_sel     (alu_a_select),
        .b_sel     (alu_b_select),
        .c_sel     (alu_c_select),
        .d_sel     (alu_d_select),
        .y1_sel    (alu_y1_select),
        .y2_sel    (alu_y2_select),
        .chk_a     (!const_a),
        .chk_y1    (write[0]),
        .chk_y2    (write[1]),
        .hazard    (hazard),
        .busy_mask (busy_mask)
    );

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: table-driven issue vectors plus
// hand-written hazard, backpressure, flush and reset sequences.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic        alu_form;
    logic [1:0]  alu_vector_perci;
    logic        const_a;
    logic [3:0]  alu_a_select, alu_b_select, alu_c_select, alu_d_select;
    logic [3:0]  alu_y1_select, alu_y2_select;
    logic [1:0]  write;
    logic        wb_valid;
    logic [3:0]  wb_sel;
    logic        flush;
    logic [15:0] stall_count;
    logic [15:0] busy_mask;

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .alu_op           (alu_op),
        .alu_form         (alu_form),
        .alu_vector_perci (alu_vector_perci),
        .const_a          (const_a),
        .alu_a_select     (alu_a_select),
        .alu_b_select     (alu_b_select),
        .alu_c_select     (alu_c_select),
        .alu_d_select     (alu_d_select),
        .alu_y1_select    (alu_y1_select),
        .alu_y2_select    (alu_y2_select),
        .write            (write),
        .wb_valid         (wb_valid),
        .wb_sel           (wb_sel),
        .flush            (flush),
        .stall_count      (stall_count),
        .busy_mask        (busy_mask)
    );

    typedef struct packed {
        logic [3:0] op;
        logic       form;
        logic [1:0] perci;
        logic       ca;
        logic [3:0] a, b, c, d, y1, y2;
        logic [1:0] wr;
    } instr_t;

    typedef struct packed {
        instr_t      ins;
        logic [15:0] exp_busy;
    } vec_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    instr_t cur;
    instr_t exp_q[$];
    vec_t   vecs[5];

    function automatic logic [33:0] pack(input instr_t i);
        return {i.ca, i.op, i.form, i.perci, i.wr, i.y2, i.y1, i.d, i.c, i.b, i.a};
    endfunction

    function automatic instr_t mk(input logic [3:0] op, input logic form, input logic [1:0] perci,
                                  input logic ca, input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] c, input logic [3:0] d, input logic [3:0] y1,
                                  input logic [3:0] y2, input logic [1:0] wr);
        instr_t i;
        i.op = op; i.form = form; i.perci = perci; i.ca = ca;
        i.a = a; i.b = b; i.c = c; i.d = d; i.y1 = y1; i.y2 = y2; i.wr = wr;
        return i;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] outs();
        return {const_a, alu_op, alu_form, alu_vector_perci, write, alu_y2_select,
                alu_y1_select, alu_d_select, alu_c_select, alu_b_select, alu_a_select};
    endfunction

    // One clock: score any issue and accept seen before the edge, then advance.
    task automatic cycle();
        instr_t e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected issue: got op 0x%0h expected none", alu_op);
            end else begin
                e = exp_q.pop_front();
                check("issue fields", 64'(outs()), 64'(pack(e)));
            end
        end
        if (flush || rst) exp_q.delete();
        if (in_valid && in_ready && !rst) exp_q.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input instr_t i);
        cur      = i;
        in_instr = pack(i);
        in_valid = 1'b1;
    endtask

    task automatic issue_one(input instr_t i);
        drive(i);
        cycle();
        in_valid = 1'b0;
        #1;
        check("latency out_valid", 64'(out_valid), 64'd1);
        cycle();
    endtask

    task automatic wb(input logic [3:0] sel);
        wb_valid = 1'b1;
        wb_sel   = sel;
        cycle();
        wb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_sel = '0; flush = 1'b0;
        cur = '0;
        vecs[0] = '{mk(4'hA, 1, 2'd2, 0, 0, 5, 6, 8, 3, 12, 2'b11), 16'h1008};
        vecs[1] = '{mk(4'h3, 0, 2'd1, 0, 1, 2, 3, 4, 0, 15, 2'b10), 16'h8000};
        vecs[2] = '{mk(4'hC, 1, 2'd3, 1, 9, 9, 9, 9, 5, 6, 2'b00), 16'h0000};
        vecs[3] = '{mk(4'h7, 0, 2'd0, 0, 2, 3, 4, 5, 9, 9, 2'b11), 16'h0200};
        vecs[4] = '{mk(4'hF, 1, 2'd1, 1, 14, 13, 12, 11, 10, 1, 2'b01), 16'h0400};

        cycle();
        cycle();
        rst = 1'b0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset fields", 64'(outs()), 64'd0);
        check("reset busy", 64'(busy_mask), 64'd0);
        check("reset stall", 64'(stall_count), 64'd0);

        for (int i = 0; i < 5; i++) begin
            issue_one(vecs[i].ins);
            check("vector busy", 64'(busy_mask), 64'(vecs[i].exp_busy));
            if (vecs[i].ins.wr[0]) wb(vecs[i].ins.y1);
            if (vecs[i].ins.wr[1]) wb(vecs[i].ins.y2);
            check("vector busy cleared", 64'(busy_mask), 64'd0);
        end

        // RAW hazard on b, released by a same-cycle writeback.
        issue_one(mk(4'h5, 0, 2'd0, 0, 1, 2, 3, 4, 7, 0, 2'b01));
        check("busy after y1=7", 64'(busy_mask), 64'h0080);
        drive(mk(4'h6, 0, 2'd0, 0, 1, 7, 3, 4, 8, 0, 2'b00));
        cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stalled out_valid", 64'(out_valid), 64'd0);
            check("stall count", 64'(stall_count), 64'(k));
            cycle();
        end
        wb_valid = 1'b1;
        wb_sel   = 4'd7;
        #1;
        check("wb unblocks", 64'(out_valid), 64'd1);
        cycle();
        wb_valid = 1'b0;
        #1;
        check("busy after wb", 64'(busy_mask), 64'd0);
        check("stall held", 64'(stall_count), 64'd3);

        // Constant A ignores a busy a_sel.
        issue_one(mk(4'h2, 0, 2'd0, 0, 0, 0, 0, 0, 7, 0, 2'b01));
        issue_one(mk(4'h3, 0, 2'd0, 1, 7, 1, 2, 3, 0, 0, 2'b00));
        check("const_a no stall", 64'(stall_count), 64'd3);
        wb(4'd7);

        // Backpressure then back-to-back throughput.
        drive(mk(4'h1, 0, 2'd0, 0, 1, 1, 1, 1, 0, 0, 2'b00));
        cycle();
        out_ready = 1'b0;
        drive(mk(4'h2, 1, 2'd1, 0, 2, 2, 2, 2, 0, 0, 2'b00));
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp in_ready", 64'(in_ready), 64'd0);
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp op stable", 64'(alu_op), 64'h1);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        for (int k = 0; k < 2; k++) begin
            drive(mk(4'(8 + k), 0, 2'd2, 1, 3, 4, 5, 6, 0, 0, 2'b00));
            #1;
            check("b2b in_ready", 64'(in_ready), 64'd1);
            check("b2b out_valid", 64'(out_valid), 64'd1);
            cycle();
        end
        in_valid = 1'b0;
        #1;
        check("drain out_valid", 64'(out_valid), 64'd1);
        cycle();
        #1;
        check("drained out_valid", 64'(out_valid), 64'd0);
        check("queue empty", 64'(exp_q.size()), 64'd0);

        // Same register set and cleared in one cycle: set wins.
        issue_one(mk(4'h4, 0, 2'd0, 0, 0, 0, 0, 0, 9, 0, 2'b01));
        check("busy y1=9", 64'(busy_mask), 64'h0200);
        drive(mk(4'hB, 0, 2'd0, 0, 1, 2, 3, 4, 9, 9, 2'b11));
        cycle();
        in_valid = 1'b0;
        #1;
        check("WAW blocked", 64'(out_valid), 64'd0);
        wb_valid = 1'b1;
        wb_sel   = 4'd9;
        #1;
        check("WAW released", 64'(out_valid), 64'd1);
        cycle();
        wb_valid = 1'b0;
        #1;
        check("set wins", 64'(busy_mask), 64'h0200);
        wb(4'd9);

        // Flush a blocked instruction; scoreboard stays.
        issue_one(mk(4'h6, 0, 2'd0, 0, 4, 4, 4, 4, 0, 1, 2'b11));
        check("busy 0x3", 64'(busy_mask), 64'h0003);
        drive(mk(4'hD, 0, 2'd0, 0, 2, 0, 2, 2, 0, 0, 2'b00));
        cycle();
        drive(mk(4'hE, 0, 2'd0, 0, 5, 5, 5, 5, 0, 0, 2'b00));
        flush = 1'b1;
        #1;
        check("flush in_ready", 64'(in_ready), 64'd0);
        check("flush out_valid", 64'(out_valid), 64'd0);
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post flush out_valid", 64'(out_valid), 64'd0);
        check("post flush in_ready", 64'(in_ready), 64'd1);
        check("post flush busy", 64'(busy_mask), 64'h0003);

        // Reset in the middle of a stall.
        drive(mk(4'h9, 0, 2'd0, 0, 2, 1, 2, 2, 0, 0, 2'b00));
        cycle();
        in_valid = 1'b0;
        cycle();
        check("stall before rst", 64'(stall_count), 64'd4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst fields", 64'(outs()), 64'd0);
        check("rst busy", 64'(busy_mask), 64'd0);
        check("rst stall", 64'(stall_count), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
